// File: rtl/hb_pkg.sv
// Shared types and constants for the heartbeat scheduler.
package hb_pkg;

  typedef enum logic [2:0] {PAUSE, REST, LUB, GAP, DUB} hb_state_e;

  localparam int unsigned HB_MS_PER_MIN = 60000;
  localparam int          HB_ACC_W      = 16;

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = v[7:4];
    lo = v[3:0];
    if (lo == 4'd9) begin
      lo = 4'd0;
      hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

endpackage

// File: rtl/hb_tick_gen.sv
// Prescaler: one-cycle tick every DIV clocks, first tick on the DIV-th cycle out of reset.
module hb_tick_gen #(
  parameter int DIV = 12000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == TC);

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/heartbeat_sched.sv
// Heartbeat scheduler: bpm rate accumulator driving a lub-dub LED envelope and BCD beat count.
// Build option HB_SIM_FAST_EN forces the tick divider to 12 clocks for simulation.
//
// state | meaning
// PAUSE | scheduling stopped, accumulator held, LED off
// REST  | running, waiting for the next beat trigger
// LUB   | first pulse, LED on
// GAP   | pause between pulses, LED off
// DUB   | second pulse, LED on; chains to LUB if a trigger is pending
module heartbeat_sched
  import hb_pkg::*;
#(
  parameter int CLK_HZ   = 12000000,
  parameter int TICK_HZ  = 1000,
  parameter int BPM_MIN  = 40,
  parameter int BPM_MAX  = 180,
  parameter int BPM_INIT = 72,
  parameter int BPM_STEP = 4,
  parameter int LUB_MS   = 100,
  parameter int GAP_MS   = 100,
  parameter int DUB_MS   = 80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_dn,
  input  logic       key_run,
  output logic       led_on,
  output logic       beat_pulse,
  output logic [7:0] bpm,
  output logic [7:0] beat_bcd,
  output logic       running
);

`ifdef HB_SIM_FAST_EN
  localparam int DIV = 12;
`else
  localparam int DIV = CLK_HZ / TICK_HZ;
`endif

  localparam logic [HB_ACC_W:0] ACC_WRAP = (HB_ACC_W+1)'(HB_MS_PER_MIN);
  localparam logic [15:0]       LUB_T    = 16'(LUB_MS);
  localparam logic [15:0]       GAP_T    = 16'(GAP_MS);
  localparam logic [15:0]       DUB_T    = 16'(DUB_MS);

  hb_state_e             state, state_nxt;
  logic [HB_ACC_W-1:0]   acc, acc_nxt;
  logic [HB_ACC_W:0]     acc_sum;
  logic [15:0]           timer, timer_nxt;
  logic                  pending, pending_nxt;
  logic [7:0]            bpm_nxt;
  logic                  tick, run_tick, trig, tc, enter_lub;

  hb_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    acc_sum     = (HB_ACC_W+1)'(acc) + (HB_ACC_W+1)'(bpm);
    run_tick    = tick && (state != PAUSE);
    trig        = run_tick && (acc_sum >= ACC_WRAP);
    acc_nxt     = acc;
    if (run_tick) acc_nxt = trig ? HB_ACC_W'(acc_sum - ACC_WRAP) : acc_sum[HB_ACC_W-1:0];

    tc          = tick && (timer == 16'd1);
    state_nxt   = state;
    timer_nxt   = timer;
    pending_nxt = pending;

    case (state)
      PAUSE: if (key_run) state_nxt = REST;
      REST: if (trig) begin
        state_nxt = LUB;
        timer_nxt = LUB_T;
      end
      LUB: begin
        if (trig) pending_nxt = 1'b1;
        if (tick) timer_nxt = timer - 16'd1;
        if (tc) begin
          state_nxt = GAP;
          timer_nxt = GAP_T;
        end
      end
      GAP: begin
        if (trig) pending_nxt = 1'b1;
        if (tick) timer_nxt = timer - 16'd1;
        if (tc) begin
          state_nxt = DUB;
          timer_nxt = DUB_T;
        end
      end
      DUB: begin
        if (trig) pending_nxt = 1'b1;
        if (tick) timer_nxt = timer - 16'd1;
        // A trigger landing on the closing tick counts as pending.
        if (tc) begin
          if (pending || trig) begin
            state_nxt   = LUB;
            timer_nxt   = LUB_T;
            pending_nxt = 1'b0;
          end else begin
            state_nxt = REST;
            timer_nxt = 16'd0;
          end
        end
      end
      default: state_nxt = REST;
    endcase

    if (key_run && (state != PAUSE)) begin
      state_nxt   = PAUSE;
      timer_nxt   = 16'd0;
      pending_nxt = 1'b0;
    end

    enter_lub = (state_nxt == LUB) && (state != LUB);

    bpm_nxt = bpm;
    if (key_up && !key_dn)
      bpm_nxt = (int'(bpm) + BPM_STEP > BPM_MAX) ? 8'(BPM_MAX) : 8'(int'(bpm) + BPM_STEP);
    else if (key_dn && !key_up)
      bpm_nxt = (int'(bpm) - BPM_STEP < BPM_MIN) ? 8'(BPM_MIN) : 8'(int'(bpm) - BPM_STEP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= REST;
      acc        <= '0;
      timer      <= 16'd0;
      pending    <= 1'b0;
      bpm        <= 8'(BPM_INIT);
      beat_bcd   <= 8'h00;
      led_on     <= 1'b0;
      beat_pulse <= 1'b0;
      running    <= 1'b1;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      timer      <= timer_nxt;
      pending    <= pending_nxt;
      bpm        <= bpm_nxt;
      led_on     <= (state_nxt == LUB) || (state_nxt == DUB);
      beat_pulse <= enter_lub;
      running    <= (state_nxt != PAUSE);
      if (enter_lub) beat_bcd <= bcd_inc(beat_bcd);
    end
  end

endmodule

// File: tb/tb_heartbeat_sched.sv
// Directed bench for heartbeat_sched: reset, rate keys, pause/resume, pending chaining, BCD wrap, mid-beat reset.
module tb_heartbeat_sched;
  import hb_pkg::*;

`ifdef HB_SIM_FAST_EN
  localparam int DF = 12;
`else
  localparam int DF = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_up = 1'b0, key_dn = 1'b0, key_run = 1'b0;
  logic k0 = 1'b0;
  logic led_on, beat_pulse, running;
  logic [7:0] bpm, beat_bcd;
  logic d2_led, d2_pulse, d2_run;
  logic [7:0] d2_bpm, d2_bcd;
  logic d3_led, d3_pulse, d3_run;
  logic [7:0] d3_bpm, d3_bcd;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  heartbeat_sched #(.CLK_HZ(12000), .TICK_HZ(1000)) dut (
    .clk(clk), .rst(rst), .key_up(key_up), .key_dn(key_dn), .key_run(key_run),
    .led_on(led_on), .beat_pulse(beat_pulse), .bpm(bpm), .beat_bcd(beat_bcd), .running(running));

  heartbeat_sched #(.CLK_HZ(1000), .TICK_HZ(1000), .BPM_INIT(180),
                    .LUB_MS(200), .GAP_MS(200), .DUB_MS(200)) dut2 (
    .clk(clk), .rst(rst), .key_up(k0), .key_dn(k0), .key_run(k0),
    .led_on(d2_led), .beat_pulse(d2_pulse), .bpm(d2_bpm), .beat_bcd(d2_bcd), .running(d2_run));

  heartbeat_sched #(.CLK_HZ(1000), .TICK_HZ(1000), .BPM_MAX(255), .BPM_INIT(250),
                    .LUB_MS(1), .GAP_MS(1), .DUB_MS(1)) dut3 (
    .clk(clk), .rst(rst), .key_up(k0), .key_dn(k0), .key_run(k0),
    .led_on(d3_led), .beat_pulse(d3_pulse), .bpm(d3_bpm), .beat_bcd(d3_bcd), .running(d3_run));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic u, input logic d, input logic r);
    key_up = u; key_dn = d; key_run = r;
    step(1);
    key_up = 1'b0; key_dn = 1'b0; key_run = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dut.state !== REST) begin errors++; $display("FAIL rst_state: got %0d want %0d", dut.state, REST); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL rst_running: got %0b want 1", running); end
    checks++; if (bpm !== 8'd72) begin errors++; $display("FAIL rst_bpm: got %0d want 72", bpm); end
    checks++; if (led_on !== 1'b0 || beat_pulse !== 1'b0) begin errors++; $display("FAIL rst_led_pulse: got %0b%0b want 00", led_on, beat_pulse); end
    checks++; if (beat_bcd !== 8'h00) begin errors++; $display("FAIL rst_bcd: got %h want 00", beat_bcd); end
    checks++; if (dut.acc !== 16'd0) begin errors++; $display("FAIL rst_acc: got %0d want 0", dut.acc); end
  endtask

  task automatic test_first_beat();
    do_reset();
    step(12*834 - 1);
    checks++; if (beat_pulse !== 1'b0) begin errors++; $display("FAIL beat_early: got %0b want 0", beat_pulse); end
    checks++; if (dut.acc !== 16'd59976) begin errors++; $display("FAIL acc_833: got %0d want 59976", dut.acc); end
    step(1);
    checks++; if (beat_pulse !== 1'b1 || led_on !== 1'b1) begin errors++; $display("FAIL beat_834: got pulse %0b led %0b want 1 1", beat_pulse, led_on); end
    checks++; if (dut.acc !== 16'd48) begin errors++; $display("FAIL acc_834: got %0d want 48", dut.acc); end
    checks++; if (beat_bcd !== 8'h01) begin errors++; $display("FAIL bcd_first: got %h want 01", beat_bcd); end
    step(1);
    checks++; if (beat_pulse !== 1'b0) begin errors++; $display("FAIL pulse_width: got %0b want 0", beat_pulse); end
    step(1198);
    checks++; if (led_on !== 1'b1) begin errors++; $display("FAIL lub_end: got %0b want 1", led_on); end
    step(1);
    checks++; if (led_on !== 1'b0) begin errors++; $display("FAIL gap_start: got %0b want 0", led_on); end
    step(1199);
    checks++; if (led_on !== 1'b0) begin errors++; $display("FAIL gap_end: got %0b want 0", led_on); end
    step(1);
    checks++; if (led_on !== 1'b1) begin errors++; $display("FAIL dub_start: got %0b want 1", led_on); end
    step(959);
    checks++; if (led_on !== 1'b1) begin errors++; $display("FAIL dub_end: got %0b want 1", led_on); end
    step(1);
    checks++; if (led_on !== 1'b0 || dut.state !== REST) begin errors++; $display("FAIL rest_after_dub: got led %0b state %0d want 0 %0d", led_on, dut.state, REST); end
  endtask

  task automatic test_keys();
    do_reset();
    repeat (5) press(1'b1, 1'b0, 1'b0);
    checks++; if (bpm !== 8'd92) begin errors++; $display("FAIL up5: got %0d want 92", bpm); end
    repeat (25) press(1'b1, 1'b0, 1'b0);
    checks++; if (bpm !== 8'd180) begin errors++; $display("FAIL up_sat: got %0d want 180", bpm); end
    press(1'b1, 1'b1, 1'b0);
    checks++; if (bpm !== 8'd180) begin errors++; $display("FAIL both_hi: got %0d want 180", bpm); end
    repeat (35) press(1'b0, 1'b1, 1'b0);
    checks++; if (bpm !== 8'd40) begin errors++; $display("FAIL dn35: got %0d want 40", bpm); end
    press(1'b0, 1'b1, 1'b0);
    checks++; if (bpm !== 8'd40) begin errors++; $display("FAIL dn_sat: got %0d want 40", bpm); end
    press(1'b1, 1'b1, 1'b0);
    checks++; if (bpm !== 8'd40) begin errors++; $display("FAIL both_lo: got %0d want 40", bpm); end
  endtask

  task automatic test_pause();
    do_reset();
    step(12*834 + 100);
    press(1'b0, 1'b0, 1'b1);
    checks++; if (dut.state !== PAUSE || led_on !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL pause_enter: got state %0d led %0b run %0b want %0d 0 0", dut.state, led_on, running, PAUSE); end
    checks++; if (dut.acc !== 16'd624) begin errors++; $display("FAIL pause_acc: got %0d want 624", dut.acc); end
    checks++; if (dut.timer !== 16'd0 || dut.pending !== 1'b0) begin errors++; $display("FAIL pause_clr: got timer %0d pend %0b want 0 0", dut.timer, dut.pending); end
    step(1200);
    checks++; if (dut.acc !== 16'd624 || dut.state !== PAUSE) begin errors++; $display("FAIL pause_hold: got acc %0d state %0d want 624 %0d", dut.acc, dut.state, PAUSE); end
    checks++; if (beat_bcd !== 8'h01) begin errors++; $display("FAIL pause_bcd: got %h want 01", beat_bcd); end
    press(1'b0, 1'b0, 1'b1);
    checks++; if (dut.state !== REST || running !== 1'b1) begin errors++; $display("FAIL resume: got state %0d run %0b want %0d 1", dut.state, running, REST); end
    step(9893);
    checks++; if (beat_pulse !== 1'b0) begin errors++; $display("FAIL resume_early: got %0b want 0", beat_pulse); end
    step(1);
    checks++; if (beat_pulse !== 1'b1 || beat_bcd !== 8'h02) begin errors++; $display("FAIL resume_beat: got pulse %0b bcd %h want 1 02", beat_pulse, beat_bcd); end
    checks++; if (dut.acc !== 16'd24) begin errors++; $display("FAIL resume_acc: got %0d want 24", dut.acc); end
  endtask

  task automatic test_pending();
    do_reset();
    step(334*DF - 1);
    checks++; if (d2_pulse !== 1'b0) begin errors++; $display("FAIL p_early: got %0b want 0", d2_pulse); end
    step(1);
    checks++; if (d2_pulse !== 1'b1 || d2_bcd !== 8'h01) begin errors++; $display("FAIL p_beat1: got pulse %0b bcd %h want 1 01", d2_pulse, d2_bcd); end
    step((700-334)*DF);
    checks++; if (dut2.state !== GAP || dut2.pending !== 1'b1) begin errors++; $display("FAIL p_set: got state %0d pend %0b want %0d 1", dut2.state, dut2.pending, GAP); end
    step((933-700)*DF);
    checks++; if (dut2.state !== DUB) begin errors++; $display("FAIL p_dub: got %0d want %0d", dut2.state, DUB); end
    step(DF);
    checks++; if (dut2.state !== LUB || d2_pulse !== 1'b1 || d2_bcd !== 8'h02 || dut2.pending !== 1'b0) begin errors++; $display("FAIL p_chain1: got state %0d pulse %0b bcd %h pend %0b want %0d 1 02 0", dut2.state, d2_pulse, d2_bcd, dut2.pending, LUB); end
    step((1400-934)*DF);
    checks++; if (dut2.state !== DUB || dut2.pending !== 1'b1) begin errors++; $display("FAIL p_set2: got state %0d pend %0b want %0d 1", dut2.state, dut2.pending, DUB); end
    step((1534-1400)*DF);
    checks++; if (dut2.state !== LUB || d2_pulse !== 1'b1 || d2_bcd !== 8'h03) begin errors++; $display("FAIL p_chain2: got state %0d pulse %0b bcd %h want %0d 1 03", dut2.state, d2_pulse, d2_bcd, LUB); end
    step((1600-1534)*DF);
    checks++; if (dut2.pending !== 1'b0) begin errors++; $display("FAIL p_dropped: got %0b want 0", dut2.pending); end
    step((1700-1600)*DF);
    checks++; if (dut2.pending !== 1'b1) begin errors++; $display("FAIL p_set3: got %0b want 1", dut2.pending); end
  endtask

  task automatic test_bcd_wrap();
    do_reset();
    step(9*240*DF);
    checks++; if (d3_pulse !== 1'b1 || d3_bcd !== 8'h09) begin errors++; $display("FAIL bcd09: got pulse %0b bcd %h want 1 09", d3_pulse, d3_bcd); end
    step(240*DF);
    checks++; if (d3_bcd !== 8'h10) begin errors++; $display("FAIL bcd10: got %h want 10", d3_bcd); end
    step(89*240*DF);
    checks++; if (d3_pulse !== 1'b1 || d3_bcd !== 8'h99) begin errors++; $display("FAIL bcd99: got pulse %0b bcd %h want 1 99", d3_pulse, d3_bcd); end
    step(240*DF - 1);
    checks++; if (d3_pulse !== 1'b0 || d3_bcd !== 8'h99) begin errors++; $display("FAIL bcd99_hold: got pulse %0b bcd %h want 0 99", d3_pulse, d3_bcd); end
    step(1);
    checks++; if (d3_pulse !== 1'b1 || d3_bcd !== 8'h00) begin errors++; $display("FAIL bcd_wrap: got pulse %0b bcd %h want 1 00", d3_pulse, d3_bcd); end
  endtask

  task automatic test_reset_mid_gap();
    int n;
    do_reset();
    repeat (27) press(1'b1, 1'b0, 1'b0);
    n = 0;
    while (beat_pulse !== 1'b1 && n < 6000) begin
      step(1);
      n++;
    end
    checks++; if (beat_pulse !== 1'b1) begin errors++; $display("FAIL mg_beat_timeout: got %0b want 1 within 6000 cycles", beat_pulse); end
    step(1250);
    checks++; if (dut.state !== GAP || led_on !== 1'b0 || bpm !== 8'd180) begin errors++; $display("FAIL mg_in_gap: got state %0d led %0b bpm %0d want %0d 0 180", dut.state, led_on, bpm, GAP); end
    do_reset();
    checks++; if (dut.state !== REST || running !== 1'b1 || led_on !== 1'b0 || beat_pulse !== 1'b0) begin errors++; $display("FAIL mg_rst_ctl: got state %0d run %0b led %0b pulse %0b", dut.state, running, led_on, beat_pulse); end
    checks++; if (bpm !== 8'd72 || beat_bcd !== 8'h00) begin errors++; $display("FAIL mg_rst_out: got bpm %0d bcd %h want 72 00", bpm, beat_bcd); end
    checks++; if (dut.acc !== 16'd0 || dut.timer !== 16'd0 || dut.pending !== 1'b0 || dut.u_tick_gen.cnt !== '0) begin errors++; $display("FAIL mg_rst_int: got acc %0d timer %0d pend %0b div %0d", dut.acc, dut.timer, dut.pending, dut.u_tick_gen.cnt); end
  endtask

  initial begin
    test_reset();
    test_first_beat();
    test_keys();
    test_pause();
    test_pending();
    test_bcd_wrap();
    test_reset_mid_gap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/heartbeat_sched.md
# heartbeat_sched

Beat scheduler for the heartbeat-light datapath. It turns a selectable rate in beats per minute into a two-phase "lub-dub" LED envelope and a two-digit BCD beat count. It sits between the debounced key/switch front end and the LED/segment drivers in `top`. It runs the whole timeline from a 1 ms tick derived from the 12 MHz `clk`.

## Interface
- `CLK_HZ`, 12000000, input clock frequency
- `TICK_HZ`, 1000, scheduler tick rate (1 ms)
- `BPM_MIN`, 40, lowest rate
- `BPM_MAX`, 180, highest rate
- `BPM_INIT`, 72, rate after reset
- `BPM_STEP`, 4, change applied per key press
- `LUB_MS`, 100, first pulse length in ticks
- `GAP_MS`, 100, gap between pulses in ticks
- `DUB_MS`, 80, second pulse length in ticks
- `clk`  in  1  system clock, 12 MHz
- `rst`  in  1  reset; one clock, reset is synchronous and active-high
- `key_up`  in  1  one-cycle pulse, debounced; rate + `BPM_STEP`
- `key_dn`  in  1  one-cycle pulse, debounced; rate − `BPM_STEP`
- `key_run`  in  1  one-cycle pulse, debounced; toggles run/pause
- `led_on`  out  1  high during the LUB and DUB states
- `beat_pulse`  out  1  one-cycle strobe on entry to LUB
- `bpm`  out  8  current rate, binary
- `beat_bcd`  out  8  beat count as {tens, ones} BCD, 00..99
- `running`  out  1  1 = scheduling, 0 = paused

## Operation
- Reset values:
  - state = REST, `running` = 1, `bpm` = `BPM_INIT`
  - accumulator = 0, pending = 0, state timer = 0
  - `led_on` = 0, `beat_pulse` = 0, `beat_bcd` = 8'h00, tick divider = 0
- Rate accumulator (16 bit, unsigned):
  - On each tick while running: if acc + bpm ≥ 60000, then acc ← acc + bpm − 60000 and raise a beat trigger; otherwise acc ← acc + bpm.
  - acc never exceeds 60000 + `BPM_MAX`, so 16 bits is sufficient.
- States:
  - PAUSE: holds acc, `led_on` = 0.
  - REST: trigger → LUB.
  - LUB: after `LUB_MS` ticks → GAP.
  - GAP: after `GAP_MS` ticks → DUB.
  - DUB: after `DUB_MS` ticks → LUB if pending is set (clear pending), else REST.
- A trigger that arrives in LUB, GAP or DUB sets pending. Pending is one deep; further triggers are dropped.
- Entering LUB:
  - asserts `beat_pulse` for exactly one cycle
  - increments `beat_bcd` in decimal: 09 → 10, 99 → 00
- `key_up` / `key_dn`:
  - `bpm` saturates at `BPM_MAX` / `BPM_MIN` (e.g. 178 + 4 → 180).
  - Keys are accepted in any state, including PAUSE.
  - acc is not cleared; the new rate applies from the next tick.
- `key_up` and `key_dn` asserted in the same cycle: no change.
- `key_run`:
  - Running → PAUSE: aborts any LUB/GAP/DUB and clears pending and the timer; acc and `beat_bcd` are held.
  - Paused → REST.
- Key pulse coincident with a tick: the rate update and the tick's accumulate both use the old `bpm` in that cycle.
- `rst` asserted in any state returns all registers to their reset values on the next edge.

## Timing
- Tick: a one-cycle strobe when the divider reaches DIV−1, with DIV = `CLK_HZ`/`TICK_HZ` (12000). The first tick occurs on the DIV-th cycle after reset deasserts.
- Registered outputs. The state changes on the cycle after the tick that ends it. `led_on` and `beat_pulse` follow the state in the same cycle.
- Each of LUB, GAP and DUB lasts exactly its parameter × DIV cycles.
- Beat period is 60000/bpm ticks on average, with ±1 tick jitter from accumulator remainders.

## Configuration
- `HB_SIM_FAST_EN`:
  - Defined: DIV is forced to 12, so one tick = 12 cycles, for simulation.
  - Undefined: DIV = `CLK_HZ`/`TICK_HZ`.
  - All other behaviour is identical.

## Structure
- Shared package `hb_pkg` holds:
  - state enum {PAUSE, REST, LUB, GAP, DUB}
  - constant `HB_MS_PER_MIN` = 60000
  - accumulator width 16
- Sub-module `hb_tick_gen`: the prescaler, parameter DIV, output `tick`. It is reset by `rst`.
- The FSM, accumulator and BCD counter live in `heartbeat_sched`.

## Test plan
All scenarios run with `HB_SIM_FAST_EN` defined.
- Reset, no keys:
  - first `beat_pulse` at the cycle after tick 834 (72·834 = 60048); acc = 48 afterwards
  - `led_on` high 1200 cycles, low 1200, high 960
  - `beat_bcd` = 8'h01
- 5× `key_up` from reset → `bpm` = 92. 30× `key_up` → `bpm` = 180 (saturated). `key_up` + `key_dn` in the same cycle → unchanged.
- `key_run` mid-LUB:
  - `led_on` drops the next cycle and the state is PAUSE
  - acc is frozen across 100 ticks
  - second `key_run` → REST, scheduling resumes from the held acc
- `bpm` = 180 with `LUB_MS`/`GAP_MS`/`DUB_MS` overridden to 200: the trigger during DUB sets pending, DUB goes directly to LUB, and a second overlapping trigger is dropped.
- Force `beat_bcd` to 8'h99 via repeated beats → next `beat_pulse` yields 8'h00.
- `rst` asserted mid-GAP → all outputs equal the reset values on the following cycle, and `bpm` = 72.
